unrnd_exp: RTL and testbench
============================

UNRND_EXP -- requirements
Module: unrnd_exp

Interface
- REQ-001 SHALL have parameter DW_IN, default 8, meaning the width of the reduced (rounded) input sample.
- REQ-002 SHALL have parameter DW_RND, default 2, meaning the number of LSBs restored; legal range 1..15.
- REQ-003 SHALL have parameter DW_OUT, default DW_IN+DW_RND, meaning the expanded output width.
- REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the dither LFSR reset value; a value of 0 SHALL be replaced by 16'hACE1.
- REQ-005 i_clk  input  1  SHALL be the single clock; all logic on its rising edge.
- REQ-006 i_rst  input  1  SHALL be the reset, synchronous and active-high.
- REQ-007 i_din  input  DW_IN  SHALL carry the reduced sample, unsigned.
- REQ-008 i_valid  input  1  SHALL flag i_din/i_mode as valid.
- REQ-009 o_ready  output  1  SHALL indicate the block can accept an input beat.
- REQ-010 i_mode  input  2  SHALL select the LSB fill: 00 zero, 01 midpoint, 10 LFSR dither, 11 zero.
- REQ-011 o_dout  output  DW_OUT  SHALL carry the expanded sample.
- REQ-012 o_valid  output  1  SHALL flag o_dout as valid.
- REQ-013 i_ready  input  1  SHALL indicate the downstream consumer accepts o_dout.
- REQ-014 o_cnt  output  16  SHALL count accepted input beats.

Function
- REQ-015 An input beat SHALL be accepted when i_valid and o_ready are both 1 on a rising edge; an output beat SHALL be consumed when o_valid and i_ready are both 1.
- REQ-016 Expansion SHALL form o_dout = {i_din, fill}; fill is DW_RND bits: zero for mode 00/11; for mode 01, MSB 1 and remaining bits 0; for mode 10, LFSR[DW_RND-1:0].
- REQ-017 i_mode SHALL be sampled per accepted beat; a mode change SHALL affect only beats accepted after it.
- REQ-018 The LFSR SHALL be 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift-left with feedback into bit 0, and SHALL advance exactly once per accepted beat in every mode, after its fill bits are used.
- REQ-019 Latency SHALL be 1 cycle: a beat accepted at edge N with the buffer empty SHALL appear on o_dout with o_valid=1 after edge N.
- REQ-020 Buffering SHALL be a 2-entry skid buffer, FIFO order: states EMPTY, ONE, FULL.
- REQ-021 EMPTY: accept -> ONE.
- REQ-022 ONE: accept without consume -> FULL; consume without accept -> EMPTY; both -> ONE.
- REQ-023 FULL: consume -> ONE; no accept.
- REQ-024 o_ready SHALL be 1 iff state is not FULL, registered, with no combinational path from i_ready.
- REQ-025 o_valid SHALL be 1 iff state is not EMPTY; o_dout SHALL be the oldest entry and SHALL stay stable while o_valid=1 and i_ready=0.
- REQ-026 o_cnt SHALL increment by 1 per accepted beat and wrap 16'hFFFF -> 16'h0000.
- REQ-027 i_din all-ones SHALL expand without overflow; the top DW_IN bits of o_dout SHALL equal i_din in every mode.

Reset
- REQ-028 With i_rst=1 at an edge, the block SHALL set state EMPTY, o_valid=0, o_ready=1 on the following cycle, o_cnt=0, LFSR=LFSR_SEED (or 16'hACE1 if 0), and o_dout=0.
- REQ-029 Reset SHALL take priority over simultaneous accept or consume; buffered beats SHALL be discarded, and no input SHALL be accepted on an edge with i_rst=1.

Verification
- REQ-030 Mode 00, i_din=8'hA5, i_ready=1 -> o_dout=10'h294 one cycle later; o_cnt=1.
- REQ-031 Mode 01, i_din=8'hFF -> o_dout=10'h3FE; mode 10 after reset with seed ACE1 -> fill=2'b01, o_dout={i_din,2'b01}.
- REQ-032 i_ready=0, send 3 beats 1,2,3 -> o_ready drops after 2 accepted; beat 3 held off; raise i_ready -> outputs 10'h004, 10'h008, 10'h00C in order, no loss or duplication.
- REQ-033 Random i_valid/i_ready, 10000 beats, mode 10 -> output stream matches reference model (LFSR advance per accepted beat); o_cnt=10000 mod 65536.
- REQ-034 Buffer FULL, assert i_rst with i_valid=1 and i_ready=1 -> next cycle o_valid=0, o_ready=1, o_cnt=0, LFSR=16'hACE1.
- REQ-035 Force o_cnt to 16'hFFFF via 65535 beats, accept one more -> o_cnt=0.

Source files
------------

// File: rtl/unrnd_exp.sv
// unrnd_exp: restores DW_RND low-order bits onto a rounded sample.
// The fill is zero, the midpoint or LFSR dither. A 2-entry skid buffer
// decouples the upstream and downstream handshakes.
module unrnd_exp #(
    parameter int          DW_IN     = 8,
    parameter int          DW_RND    = 2,
    parameter int          DW_OUT    = DW_IN + DW_RND,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DW_IN-1:0]  i_din,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_mode,
    output logic [DW_OUT-1:0] o_dout,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [15:0]       o_cnt
);

    // An all-zero seed would lock the LFSR, so it falls back to the default seed
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    state_t              state;
    logic [15:0]         lfsr;
    logic [15:0]         lfsr_next;
    logic                lfsr_fb;
    logic [DW_RND-1:0]   fill;
    logic [DW_OUT-1:0]   expanded;
    logic [DW_OUT-1:0]   slot0;
    logic [DW_OUT-1:0]   slot1;
    logic                accept;
    logic                consume;

    assign accept  = i_valid && o_ready;
    assign consume = o_valid && i_ready;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign lfsr_next = {lfsr[14:0], lfsr_fb};

    // Select the restored LSBs for the beat currently offered
    always_comb begin
        fill = '0;
        case (i_mode)
            2'b01:   fill[DW_RND-1] = 1'b1;
            2'b10:   fill = lfsr[DW_RND-1:0];
            default: fill = '0;
        endcase
    end

    assign expanded = DW_OUT'({i_din, fill});
    assign o_dout   = slot0;

    // Skid-buffer FSM: slot0 is always the oldest entry; flags are registered from the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_EMPTY;
            slot0   <= '0;
            slot1   <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_cnt   <= 16'h0000;
            lfsr    <= SEED_EFF;
        end else begin
            if (accept) begin
                o_cnt <= o_cnt + 16'd1;
                lfsr  <= lfsr_next;
            end
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        slot0   <= expanded;
                        state   <= ST_ONE;
                        o_valid <= 1'b1;
                        o_ready <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !consume) begin
                        slot1   <= expanded;
                        state   <= ST_FULL;
                        o_valid <= 1'b1;
                        o_ready <= 1'b0;
                    end else if (!accept && consume) begin
                        state   <= ST_EMPTY;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                    end else if (accept && consume) begin
                        slot0 <= expanded;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        slot0   <= slot1;
                        state   <= ST_ONE;
                        o_valid <= 1'b1;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unrnd_exp.sv
// tb_unrnd_exp: table vectors, hand-written handshake sequences and a long
// randomized run checked against a queue-based reference model.
module tb_unrnd_exp;

    logic        clk;
    logic        i_rst;
    logic [7:0]  i_din;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_mode;
    logic [9:0]  o_dout;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_cnt;

    int n_checks;
    int n_fail;
    int n_acc;
    bit check_en;

    logic [9:0]  exp_q[$];
    logic [15:0] m_lfsr;
    logic [15:0] m_cnt;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] din;
        logic [9:0] exp_dout;
    } vec_t;

    vec_t vecs[7];

    unrnd_exp #(
        .DW_IN(8),
        .DW_RND(2),
        .DW_OUT(10),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_din(i_din),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_mode(i_mode),
        .o_dout(o_dout),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_cnt(o_cnt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Polynomial x^16+x^14+x^13+x^11+1: feedback from exponents 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Expanded value: sample shifted up by two bits plus the mode's fill
    function automatic logic [9:0] expand(input logic [7:0] d, input logic [1:0] m,
                                          input logic [15:0] l);
        int f;
        case (m)
            2'b01:   f = 2;
            2'b10:   f = int'(l[1:0]);
            default: f = 0;
        endcase
        return 10'(int'(d) * 4 + f);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("o_valid", 32'(o_valid), 32'(exp_q.size() > 0));
        check("o_ready", 32'(o_ready), 32'(exp_q.size() < 2));
        check("o_cnt", 32'(o_cnt), 32'(m_cnt));
        if (exp_q.size() > 0)
            check("o_dout", 32'(o_dout), 32'(exp_q[0]));
    endtask

    // One cycle: drive inputs, check current outputs, advance model, step the clock
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] m,
                                 input logic r);
        bit acc;
        bit con;
        i_valid = v;
        i_din   = d;
        i_mode  = m;
        i_ready = r;
        if (check_en)
            checkOutput();
        acc = v && (exp_q.size() < 2);
        con = r && (exp_q.size() > 0);
        if (con)
            void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(expand(d, m, m_lfsr));
            m_lfsr = lfsr_step(m_lfsr);
            m_cnt  = m_cnt + 16'd1;
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    // Reset with the given handshake inputs held, then check the reset state
    task automatic doReset(input logic v, input logic r);
        i_rst   = 1'b1;
        i_valid = v;
        i_ready = r;
        i_din   = 8'hFF;
        i_mode  = 2'b10;
        @(posedge clk);
        #1;
        i_rst   = 1'b0;
        i_valid = 1'b0;
        exp_q.delete();
        m_lfsr = 16'hACE1;
        m_cnt  = 16'h0000;
        n_acc  = 0;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_cnt", 32'(o_cnt), 32'd0);
        check("rst_dout", 32'(o_dout), 32'd0);
    endtask

    initial begin
        clk      = 1'b0;
        i_rst    = 1'b0;
        i_din    = '0;
        i_valid  = 1'b0;
        i_mode   = 2'b00;
        i_ready  = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        n_acc    = 0;
        check_en = 1'b1;
        m_lfsr   = 16'hACE1;
        m_cnt    = 16'h0000;

        vecs[0] = '{2'b00, 8'hA5, 10'h294};
        vecs[1] = '{2'b01, 8'hFF, 10'h3FE};
        vecs[2] = '{2'b10, 8'h00, 10'h001};
        vecs[3] = '{2'b10, 8'hFF, 10'h3FD};
        vecs[4] = '{2'b11, 8'h3C, 10'h0F0};
        vecs[5] = '{2'b00, 8'hFF, 10'h3FC};
        vecs[6] = '{2'b01, 8'h00, 10'h002};

        // Single beats from reset: one-cycle latency, fill per mode
        for (int i = 0; i < 7; i++) begin
            doReset(1'b0, 1'b0);
            applyStimulus(1'b1, vecs[i].din, vecs[i].mode, 1'b1);
            check("tbl_dout", 32'(o_dout), 32'(vecs[i].exp_dout));
            check("tbl_cnt", 32'(o_cnt), 32'd1);
            applyStimulus(1'b0, 8'h00, 2'b00, 1'b1);
        end

        // Mode changes apply per accepted beat; the LFSR advances in every mode
        doReset(1'b0, 1'b0);
        applyStimulus(1'b1, 8'h10, 2'b00, 1'b1);
        check("mode_seq0", 32'(o_dout), 32'h040);
        applyStimulus(1'b1, 8'h10, 2'b01, 1'b1);
        check("mode_seq1", 32'(o_dout), 32'h042);
        applyStimulus(1'b1, 8'h10, 2'b10, 1'b1);
        check("mode_seq2", 32'(o_dout), 32'h043);
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b1);

        // Backpressure: two beats fill the buffer, the third is held off
        doReset(1'b0, 1'b0);
        applyStimulus(1'b1, 8'd1, 2'b00, 1'b0);
        applyStimulus(1'b1, 8'd2, 2'b00, 1'b0);
        check("skid_full_ready", 32'(o_ready), 32'd0);
        applyStimulus(1'b1, 8'd3, 2'b00, 1'b0);
        check("skid_hold_dout", 32'(o_dout), 32'h004);
        check("skid_hold_cnt", 32'(o_cnt), 32'd2);
        check("skid_out0", 32'(o_dout), 32'h004);
        applyStimulus(1'b1, 8'd3, 2'b00, 1'b1);
        check("skid_out1", 32'(o_dout), 32'h008);
        applyStimulus(1'b1, 8'd3, 2'b00, 1'b1);
        check("skid_out2", 32'(o_dout), 32'h00C);
        applyStimulus(1'b0, 8'd0, 2'b00, 1'b1);
        check("skid_drained", 32'(o_valid), 32'd0);
        check("skid_cnt", 32'(o_cnt), 32'd3);

        // Reset while full with a simultaneous accept/consume attempt
        doReset(1'b0, 1'b0);
        applyStimulus(1'b1, 8'd1, 2'b00, 1'b0);
        applyStimulus(1'b1, 8'd2, 2'b00, 1'b0);
        check("pre_rst_full", 32'(o_ready), 32'd0);
        doReset(1'b1, 1'b1);
        applyStimulus(1'b1, 8'h00, 2'b10, 1'b1);
        check("seed_fill", 32'(o_dout), 32'h001);
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b1);

        // Random handshakes, dither mode, 10000 accepted beats
        doReset(1'b0, 1'b0);
        for (int cyc = 0; cyc < 40000 && n_acc < 10000; cyc++) begin
            applyStimulus(($urandom_range(0, 7) != 0) && (n_acc < 10000),
                          8'($urandom), 2'b10, ($urandom_range(0, 7) != 0));
        end
        check("rand_beats", 32'(n_acc), 32'd10000);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, 8'h00, 2'b00, 1'b1);
        check("rand_cnt", 32'(o_cnt), 32'd10000);

        // Stream with random modes up to 65535 beats, then wrap the counter
        for (int cyc = 0; cyc < 60000 && n_acc < 65535; cyc++) begin
            check_en = (cyc < 500);
            applyStimulus(1'b1, 8'($urandom), 2'($urandom), 1'b1);
        end
        check_en = 1'b1;
        check("fill_beats", 32'(n_acc), 32'd65535);
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b1);
        check("cnt_max", 32'(o_cnt), 32'hFFFF);
        applyStimulus(1'b1, 8'h5A, 2'b00, 1'b1);
        check("cnt_wrap", 32'(o_cnt), 32'h0000);
        check("wrap_dout", 32'(o_dout), 32'h168);
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b1);
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
